// File: rtl/uart_rx_word_builder.sv
// UART 8N1 receiver that pairs consecutive good bytes (low byte first) into 16-bit words.
// Define UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
`timescale 1ns/1ps

module uart_rx_word_builder #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [15:0] word_data,
    output logic        word_valid,
    output logic [15:0] lo_byte,
    output logic [2:0]  sel,
    output logic        frame_err,
    output logic        parity_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [7:0] data);
        even_parity = ^data;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4
    } state_t;
`endif

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     byte0_q, byte0_d;
    logic [15:0]    word_data_q, word_data_d;
    logic           word_valid_q, word_valid_d;
    logic [2:0]     sel_q, sel_d;
    logic           frame_err_q, frame_err_d;
    logic           parity_err_q, parity_err_d;
    logic           rx_meta_q, rx_sync_q;
    logic           rx_s;
    logic           bit_tick_s;
    logic           par_flag_s;

`ifdef UART_RX_PARITY_EN
    logic           par_err_q, par_err_d;
    assign par_flag_s = par_err_q;
`else
    assign par_flag_s = 1'b0;
`endif

    assign rx_s       = rx_sync_q;
    assign bit_tick_s = (cnt_q == FULL_M1);

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            byte0_q      <= 8'h00;
            word_data_q  <= 16'h0000;
            word_valid_q <= 1'b0;
            sel_q        <= 3'b000;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte0_q      <= byte0_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            sel_q        <= sel_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    // Bit-level FSM plus byte pairing, evaluated at the STOP sample.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte0_d      = byte0_q;
        word_data_d  = word_data_q;
        word_valid_d = 1'b0;
        sel_d        = sel_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d    = par_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d   = ST_START;
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_tick_s) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick_s) begin
                    cnt_d     = '0;
                    par_err_d = (rx_s != even_parity(shift_q));
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick_s) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    if (!rx_s || par_flag_s) begin
                        frame_err_d  = !rx_s;
                        parity_err_d = par_flag_s;
                        sel_d        = 3'b000;
                    end else if (sel_q == 3'b000) begin
                        byte0_d = shift_q;
                        sel_d   = 3'b001;
                    end else begin
                        word_data_d  = {shift_q, byte0_q};
                        word_valid_d = 1'b1;
                        sel_d        = 3'b000;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign word_data  = word_data_q;
    assign word_valid = word_valid_q;
    assign lo_byte    = {8'h00, byte0_q};
    assign sel        = sel_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

endmodule

// File: doc/uart_rx_word_builder.md
# uart_rx_word_builder

Serial front end of the UART receive path. Deserializes 8N1 frames from the `rx` pin and packs two consecutive bytes, low byte first, into a 16-bit word. Outputs the assembled word, the pending low byte and a 3-bit `sel` phase code. These feed the downstream 16-bit receive-path selector, which picks its `in0`/`in1` source on `sel == 3'b000`.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit period (50 MHz / 115200); legal range 8..65535.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; deassertion is synchronous to `clk` externally.
- `rx`  in  1  asynchronous serial line; idles high.
- `word_data`  out  16  last completed word, {byte1, byte0}; held until the next word completes.
- `word_valid`  out  1  one-cycle pulse when `word_data` updates.
- `lo_byte`  out  16  zero-extended pending low byte, {8'h00, byte0}.
- `sel`  out  3  phase: 3'b000 waiting for low byte; 3'b001 low byte held, waiting for high byte.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit.
- `parity_err`  out  1  one-cycle pulse on a parity mismatch; constant 0 when parity is compiled out.

## Operation
- `rx` passes through a 2-flop synchronizer, reset value 1. Only the synchronized `rx_s` is used.
- Bit FSM states: IDLE, START, DATA, PARITY (only when parity is compiled in), STOP.
  - IDLE -> START: `rx_s` == 0; bit counter cleared.
  - START: at count CLKS_PER_BIT/2 - 1 (integer division), sample `rx_s`. If 0, counter cleared and -> DATA. If 1, false start -> IDLE with no error flagged.
  - DATA: sample at each count CLKS_PER_BIT-1; shift LSB-first into an 8-bit register. After 8 samples -> PARITY or STOP.
  - PARITY: sample one bit; an even-parity mismatch sets an internal error flag for the frame.
  - STOP: sample one bit, then -> IDLE.
- STOP sample == 0: pulse `frame_err`, discard the byte, force `sel` to 3'b000.
- Parity flag set at the STOP sample: pulse `parity_err`, discard the byte, force `sel` to 3'b000. If the stop bit is also bad, both errors pulse in the same cycle.
- Good byte while `sel` == 000: load byte0, `sel` <= 001.
- Good byte while `sel` == 001: `word_data` <= {byte, byte0}, pulse `word_valid`, `sel` <= 000.
- `lo_byte` retains byte0 after the word completes. It is overwritten only by the next good low byte.
- Counters: bit-period counter is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 at each sample point; bit index is 3 bits.
- A new falling edge is accepted in the cycle after returning to IDLE; back-to-back frames are supported with no idle gap.
- Reset values (asynchronous, on `rst_n` low): FSM IDLE, counters 0, `word_data` 16'h0000, `word_valid` 0, `lo_byte` 16'h0000, `sel` 3'b000, `frame_err` 0, `parity_err` 0.
- Reset asserted mid-frame aborts the frame and discards any pending low byte. After release the FSM waits for a fresh falling edge. A line still low at release is treated as a start bit and handled by the mid-bit check.

## Timing
- Input latency: `rx` pin to `rx_s` is 2 cycles.
- Start-edge detect to first data sample: CLKS_PER_BIT/2 + CLKS_PER_BIT cycles.
- `word_valid`, `frame_err`, `parity_err` and the `sel`/`word_data`/`lo_byte` updates all become visible 1 cycle after the STOP sample cycle (registered outputs).
- `word_valid` is exactly one cycle wide. There is no backpressure; the consumer must capture `word_data` before the next word completes, which is at least 20 bit periods later.
- No combinational path from `rx` to any output.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1; the PARITY state is present; `parity_err` is live.
- `UART_RX_PARITY_EN` undefined: frame is 8N1; the PARITY state and parity logic are removed; `parity_err` is tied 0.

## Test plan
- Reset: hold `rst_n`=0 with `rx` toggling -> all outputs at their reset values, `sel`=000. Release -> no pulses until a valid frame arrives.
- CLKS_PER_BIT=16, send 0x34 then 0x12 back-to-back -> after the first frame `sel`=001 and `lo_byte`=16'h0034. After the second, a single-cycle `word_valid` with `word_data`=16'h1234 and `sel`=000.
- Glitch: drive `rx` low for 4 cycles with CLKS_PER_BIT=16 -> FSM returns to IDLE; no `frame_err`; `sel` unchanged.
- Send 0xAA, then a frame 0x55 with stop bit 0 -> `frame_err` pulses once; `sel`=000; `word_data` unchanged; `lo_byte` stays 16'h00AA. Then send 0x01, 0x02 -> `word_data`=16'h0201.
- Assert `rst_n` during bit 4 of the high byte after low byte 0x77 -> `sel`=000, `lo_byte`=0. The next two good frames 0x11, 0x22 -> `word_data`=16'h2211.
- With `UART_RX_PARITY_EN`: send 0x03 with parity bit 1 -> `parity_err` pulses and the byte is discarded. Send 0x03 with parity bit 0 -> byte accepted and `sel`=001.
